// File: rtl/bcd_counter_disp.sv
// bcd_counter_disp: prescaled up/down BCD counter with registered active-low 7-segment outputs.
// Define BCD_DISP_LZB_EN to blank leading zero digits (digit 0 is always shown).
module bcd_counter_disp #(
    parameter int DIGITS   = 3,
    parameter int TICK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [8*DIGITS-1:0]   seg,
    output logic                  tick,
    output logic                  wrap
);
    localparam int PW = $clog2(TICK_DIV);

    function automatic logic [7:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 8'hC0;
            4'd1:    enc = 8'hF9;
            4'd2:    enc = 8'hA4;
            4'd3:    enc = 8'hB0;
            4'd4:    enc = 8'h99;
            4'd5:    enc = 8'h92;
            4'd6:    enc = 8'h82;
            4'd7:    enc = 8'hF8;
            4'd8:    enc = 8'h80;
            default: enc = 8'h90;
        endcase
    endfunction

    function automatic logic [8*DIGITS-1:0] rst_pat();
        rst_pat = '0;
        for (int i = 0; i < DIGITS; i++)
`ifdef BCD_DISP_LZB_EN
            rst_pat[8*i+:8] = (i == 0) ? 8'hC0 : 8'hFF;
`else
            rst_pat[8*i+:8] = 8'hC0;
`endif
    endfunction

    localparam logic [8*DIGITS-1:0] RST_SEG = rst_pat();

    logic [PW-1:0]         presc;
    logic                  term;
    logic                  cy;
    logic [4*DIGITS-1:0]   step_val;
    logic [4*DIGITS-1:0]   sat_val;
    logic [8*DIGITS-1:0]   seg_next;
`ifdef BCD_DISP_LZB_EN
    logic                  lead_nz;
`endif

    assign term = en && (presc == PW'(TICK_DIV - 1));

    // cy ripples through the digits: it ends high only when every digit rolls over
    always_comb begin
        step_val = bcd;
        sat_val  = load_val;
        seg_next = '0;
        cy       = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            sat_val[4*i+:4] = (load_val[4*i+:4] > 4'd9) ? 4'd9 : load_val[4*i+:4];
            if (cy)
                step_val[4*i+:4] = up ? ((bcd[4*i+:4] == 4'd9) ? 4'd0 : bcd[4*i+:4] + 4'd1)
                                      : ((bcd[4*i+:4] == 4'd0) ? 4'd9 : bcd[4*i+:4] - 4'd1);
            cy = cy && (up ? (bcd[4*i+:4] == 4'd9) : (bcd[4*i+:4] == 4'd0));
        end
`ifdef BCD_DISP_LZB_EN
        lead_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead_nz = lead_nz || (bcd[4*i+:4] != 4'd0);
            seg_next[8*i+:8] = (lead_nz || i == 0) ? enc(bcd[4*i+:4]) : 8'hFF;
        end
`else
        for (int i = 0; i < DIGITS; i++)
            seg_next[8*i+:8] = enc(bcd[4*i+:4]);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            bcd   <= '0;
            seg   <= RST_SEG;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            presc <= (load || term) ? '0 : en ? presc + 1'b1 : presc;
            bcd   <= load ? sat_val : term ? step_val : bcd;
            seg   <= seg_next;
            tick  <= term;
            wrap  <= term && !load && cy;
        end
    end
endmodule

// File: tb/tb_bcd_counter_disp.sv
// tb_bcd_counter_disp: directed checks of bcd_counter_disp with DIGITS=3, TICK_DIV=4.
module tb_bcd_counter_disp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [11:0] load_val = '0;
    logic [11:0] bcd;
    logic [23:0] seg;
    logic        tick;
    logic        wrap;
    int          n_checks = 0;
    int          n_pass = 0;

`ifdef BCD_DISP_LZB_EN
    localparam logic [23:0] SEG_ZERO = 24'hFFFFC0;
`else
    localparam logic [23:0] SEG_ZERO = 24'hC0C0C0;
`endif

    bcd_counter_disp #(.DIGITS(3), .TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .bcd(bcd), .seg(seg), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (bcd !== 12'h000) $display("FAIL reset_bcd got %h want 000", bcd); else n_pass++;
        n_checks++;
        if (seg !== SEG_ZERO) $display("FAIL reset_seg got %h want %h", seg, SEG_ZERO); else n_pass++;
        n_checks++;
        if ({tick, wrap} !== 2'b00) $display("FAIL reset_pulses got %b want 00", {tick, wrap}); else n_pass++;
        rst = 1'b0;
        en = 1'b1;
        up = 1'b1;
    endtask

    task automatic test_count_up();
        logic [11:0] exp;
        for (int k = 1; k <= 40; k++) begin
            step();
            exp = 12'(((k / 4) / 10) << 4 | ((k / 4) % 10));
            n_checks++;
            if (tick !== (k % 4 == 0)) $display("FAIL up_tick k=%0d got %b want %b", k, tick, (k % 4 == 0)); else n_pass++;
            n_checks++;
            if (bcd !== exp) $display("FAIL up_bcd k=%0d got %h want %h", k, bcd, exp); else n_pass++;
        end
        step();
        n_checks++;
        if (seg[15:0] !== 16'hF9C0) $display("FAIL up_seg got %h want F9C0", seg[15:0]); else n_pass++;
    endtask

    task automatic test_wrap_up();
        load = 1'b1;
        load_val = 12'h999;
        step();
        load = 1'b0;
        n_checks++;
        if (bcd !== 12'h999) $display("FAIL wrapup_load got %h want 999", bcd); else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if ({tick, wrap} !== 2'b00) $display("FAIL wrapup_early k=%0d got %b want 00", k, {tick, wrap}); else n_pass++;
        end
        step();
        n_checks++;
        if ({bcd, tick, wrap} !== {12'h000, 2'b11}) $display("FAIL wrapup_edge got %h %b want 000 11", bcd, {tick, wrap}); else n_pass++;
        step();
        n_checks++;
        if (wrap !== 1'b0) $display("FAIL wrapup_pulse got %b want 0", wrap); else n_pass++;
    endtask

    task automatic test_wrap_down();
        load = 1'b1;
        load_val = 12'h000;
        step();
        load = 1'b0;
        up = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if ({bcd, wrap} !== {12'h000, 1'b0}) $display("FAIL wrapdn_early got %h %b want 000 0", bcd, wrap); else n_pass++;
        step();
        n_checks++;
        if ({bcd, tick, wrap} !== {12'h999, 2'b11}) $display("FAIL wrapdn_edge got %h %b want 999 11", bcd, {tick, wrap}); else n_pass++;
        step();
        n_checks++;
        if (seg !== 24'h909090) $display("FAIL wrapdn_seg got %h want 909090", seg); else n_pass++;
        n_checks++;
        if (wrap !== 1'b0) $display("FAIL wrapdn_pulse got %b want 0", wrap); else n_pass++;
        up = 1'b1;
    endtask

    task automatic test_load_sat();
        en = 1'b0;
        load = 1'b1;
        load_val = 12'h1F5;
        step();
        load = 1'b0;
        n_checks++;
        if (bcd !== 12'h195) $display("FAIL sat_1f5 got %h want 195", bcd); else n_pass++;
        step();
        n_checks++;
        if (seg !== 24'hF99092) $display("FAIL sat_seg got %h want F99092", seg); else n_pass++;
        load = 1'b1;
        load_val = 12'hFAB;
        step();
        load = 1'b0;
        n_checks++;
        if (bcd !== 12'h999) $display("FAIL sat_fab got %h want 999", bcd); else n_pass++;
        en = 1'b1;
    endtask

    task automatic test_load_on_tick();
        load = 1'b1;
        load_val = 12'h999;
        step();
        load = 1'b0;
        step();
        step();
        step();
        load = 1'b1;
        load_val = 12'h123;
        step();
        load = 1'b0;
        n_checks++;
        if ({bcd, tick, wrap} !== {12'h123, 2'b10}) $display("FAIL ldtick got %h %b want 123 10", bcd, {tick, wrap}); else n_pass++;
        step();
        step();
        step();
        n_checks++;
        if ({bcd, tick} !== {12'h123, 1'b0}) $display("FAIL ldtick_hold got %h %b want 123 0", bcd, tick); else n_pass++;
        step();
        n_checks++;
        if ({bcd, tick} !== {12'h124, 1'b1}) $display("FAIL ldtick_next got %h %b want 124 1", bcd, tick); else n_pass++;
    endtask

    task automatic test_en_hold();
        load = 1'b1;
        load_val = 12'h500;
        step();
        load = 1'b0;
        step();
        step();
        en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if ({bcd, tick, wrap} !== {12'h500, 2'b00}) $display("FAIL hold k=%0d got %h %b want 500 00", k, bcd, {tick, wrap}); else n_pass++;
        end
        en = 1'b1;
        step();
        n_checks++;
        if ({bcd, tick} !== {12'h500, 1'b0}) $display("FAIL hold_resume got %h %b want 500 0", bcd, tick); else n_pass++;
        step();
        n_checks++;
        if ({bcd, tick} !== {12'h501, 1'b1}) $display("FAIL hold_tick got %h %b want 501 1", bcd, tick); else n_pass++;
    endtask

    task automatic test_reset_mid();
        step();
        step();
        rst = 1'b1;
        load = 1'b1;
        load_val = 12'h777;
        step();
        n_checks++;
        if ({bcd, tick, wrap} !== {12'h000, 2'b00}) $display("FAIL rstmid got %h %b want 000 00", bcd, {tick, wrap}); else n_pass++;
        n_checks++;
        if (seg !== SEG_ZERO) $display("FAIL rstmid_seg got %h want %h", seg, SEG_ZERO); else n_pass++;
        rst = 1'b0;
        load = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if ({bcd, tick} !== {12'h000, 1'b0}) $display("FAIL rstmid_early got %h %b want 000 0", bcd, tick); else n_pass++;
        step();
        n_checks++;
        if ({bcd, tick} !== {12'h001, 1'b1}) $display("FAIL rstmid_tick got %h %b want 001 1", bcd, tick); else n_pass++;
    endtask

`ifdef BCD_DISP_LZB_EN
    task automatic test_lzb();
        en = 1'b0;
        load = 1'b1;
        load_val = 12'h007;
        step();
        load = 1'b0;
        step();
        n_checks++;
        if (seg !== 24'hFFFFF8) $display("FAIL lzb_007 got %h want FFFFF8", seg); else n_pass++;
        load = 1'b1;
        load_val = 12'h000;
        step();
        load = 1'b0;
        step();
        n_checks++;
        if (seg !== 24'hFFFFC0) $display("FAIL lzb_000 got %h want FFFFC0", seg); else n_pass++;
        en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load_sat();
        test_load_on_tick();
        test_en_hold();
        test_reset_mid();
`ifdef BCD_DISP_LZB_EN
        test_lzb();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
